// File: rtl/z0_histogram_accumulator_if.sv
// Track-set input stream and per-event histogram output of z0_histogram_accumulator.
// slave = accumulator side; master = producer/consumer side.
interface z0_histogram_accumulator_if;
    localparam int TRACKS_IN_SET = 18;
    localparam int HIST_BINS     = 72;
    localparam int BIN_WIDTH     = 9;

    typedef struct packed {
        logic [10:0] spare;
        logic [2:0]  mva;
        logic [6:0]  hit_mask;
        logic [2:0]  bend_chi2;
        logic [3:0]  chi2;
        logic [12:0] d0;
        logic [11:0] z0;
        logic [15:0] tan_l;
        logic [11:0] phi;
        logic [14:0] pt;
    } t_track_word_struct;

    logic                                         in_valid;
    logic                                         in_last;
    t_track_word_struct [TRACKS_IN_SET-1:0]       in_tracks;
    logic [TRACKS_IN_SET-1:0]                     in_track_valid;

    logic                                         hist_valid;
    logic [HIST_BINS*BIN_WIDTH-1:0]               hist_out;
    logic [6:0]                                   hist_sets;
    logic                                         set_count_err;

    modport master (
        output in_valid, in_last, in_tracks, in_track_valid,
        input  hist_valid, hist_out, hist_sets, set_count_err
    );

    modport slave (
        input  in_valid, in_last, in_tracks, in_track_valid,
        output hist_valid, hist_out, hist_sets, set_count_err
    );
endinterface

// File: rtl/z0_histogram_accumulator.sv
// Bins valid tracks by z0 into a 72-bin clipped-pT histogram, emitted once per event (optional Z0HIST_QUALITY_CUT_EN).
// Latency 3 cycles from the event's last set to hist_valid; no backpressure, every in_valid cycle is consumed.
module z0_histogram_accumulator (
    input  logic                      clk,
    input  logic                      rst_n,
    z0_histogram_accumulator_if.slave bus
);
    localparam int TRACKS_IN_SET = 18;
    localparam int HIST_BINS     = 72;
    localparam int BIN_WIDTH     = 9;
    localparam int SETS_IN_EVENT = 95;
    localparam int PT_MAX        = 127;
    localparam int CHI2_MAX      = 10;
    localparam int SUM_WIDTH     = 12;
    localparam logic [BIN_WIDTH-1:0] BIN_MAX = '1;

    // Stage 1: per-track bin index, clipped weight and contribution gate
    logic [6:0]               bin_c [TRACKS_IN_SET];
    logic [6:0]               wt_c  [TRACKS_IN_SET];
    logic [TRACKS_IN_SET-1:0] use_c;

    always_comb begin
        use_c = '0;
        for (int t = 0; t < TRACKS_IN_SET; t++) begin
            bin_c[t] = 7'(({1'b0, bus.in_tracks[t].z0, 6'b0} + {4'b0, bus.in_tracks[t].z0, 3'b0}) >> 12);
            wt_c[t]  = (bus.in_tracks[t].pt[13:0] > 14'(PT_MAX)) ? 7'(PT_MAX) : bus.in_tracks[t].pt[6:0];
`ifdef Z0HIST_QUALITY_CUT_EN
            use_c[t] = bus.in_valid && bus.in_track_valid[t] &&
                       (bus.in_tracks[t].chi2 <= 4'(CHI2_MAX)) && (bus.in_tracks[t].hit_mask != '0);
`else
            use_c[t] = bus.in_valid && bus.in_track_valid[t];
`endif
        end
    end

    logic [6:0] set_cnt;
    logic [6:0] set_num;
    logic       at_max;
    logic       ev_end;
    logic       ev_err;

    assign set_num = set_cnt + 7'd1;
    assign at_max  = (set_num == 7'(SETS_IN_EVENT));
    assign ev_end  = bus.in_valid && (bus.in_last || at_max);
    // Error when in_last and the full-length count disagree
    assign ev_err  = ev_end && (bus.in_last != at_max);

    logic [6:0]               s1_bin [TRACKS_IN_SET];
    logic [6:0]               s1_wt  [TRACKS_IN_SET];
    logic [TRACKS_IN_SET-1:0] s1_use;
    logic                     s1_end;
    logic                     s1_err;
    logic [6:0]               s1_sets;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt <= '0;
            s1_use  <= '0;
            s1_end  <= 1'b0;
            s1_err  <= 1'b0;
            s1_sets <= '0;
            for (int t = 0; t < TRACKS_IN_SET; t++) begin
                s1_bin[t] <= '0;
                s1_wt[t]  <= '0;
            end
        end else begin
            if (bus.in_valid) begin
                set_cnt <= ev_end ? 7'd0 : set_num;
            end
            s1_use  <= use_c;
            s1_bin  <= bin_c;
            s1_wt   <= wt_c;
            s1_end  <= ev_end;
            s1_err  <= ev_err;
            s1_sets <= set_num;
        end
    end

    // Stage 2: per-bin weight sum over all contributing tracks
    logic [SUM_WIDTH-1:0] sum_c  [HIST_BINS];
    logic [SUM_WIDTH-1:0] s2_sum [HIST_BINS];
    logic                 s2_end;
    logic                 s2_err;
    logic [6:0]           s2_sets;

    always_comb begin
        for (int b = 0; b < HIST_BINS; b++) begin
            sum_c[b] = '0;
            for (int t = 0; t < TRACKS_IN_SET; t++) begin
                if (s1_use[t] && (s1_bin[t] == 7'(b))) begin
                    sum_c[b] = sum_c[b] + SUM_WIDTH'(s1_wt[t]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_end  <= 1'b0;
            s2_err  <= 1'b0;
            s2_sets <= '0;
            for (int b = 0; b < HIST_BINS; b++) begin
                s2_sum[b] <= '0;
            end
        end else begin
            s2_sum  <= sum_c;
            s2_end  <= s1_end;
            s2_err  <= s1_err;
            s2_sets <= s1_sets;
        end
    end

    // Stage 3: saturating accumulate; the event-end set is captured and acc restarts from zero
    logic [SUM_WIDTH:0]   tot_c [HIST_BINS];
    logic [BIN_WIDTH-1:0] sat_c [HIST_BINS];
    logic [BIN_WIDTH-1:0] acc   [HIST_BINS];
    logic [BIN_WIDTH-1:0] fin   [HIST_BINS];
    logic                 fin_vld;
    logic                 fin_err;
    logic [6:0]           fin_sets;

    always_comb begin
        for (int b = 0; b < HIST_BINS; b++) begin
            tot_c[b] = {{(SUM_WIDTH+1-BIN_WIDTH){1'b0}}, acc[b]} + {1'b0, s2_sum[b]};
            sat_c[b] = (tot_c[b] > (SUM_WIDTH+1)'(BIN_MAX)) ? BIN_MAX : tot_c[b][BIN_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_vld  <= 1'b0;
            fin_err  <= 1'b0;
            fin_sets <= '0;
            for (int b = 0; b < HIST_BINS; b++) begin
                acc[b] <= '0;
                fin[b] <= '0;
            end
        end else begin
            fin_vld  <= s2_end;
            fin_err  <= s2_err;
            fin_sets <= s2_sets;
            for (int b = 0; b < HIST_BINS; b++) begin
                acc[b] <= s2_end ? '0 : sat_c[b];
                if (s2_end) begin
                    fin[b] <= sat_c[b];
                end
            end
        end
    end

    logic [HIST_BINS*BIN_WIDTH-1:0] hist_q;
    logic                           hist_vld_q;
    logic [6:0]                     hist_sets_q;
    logic                           err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            hist_vld_q  <= 1'b0;
            hist_sets_q <= '0;
            err_q       <= 1'b0;
        end else begin
            hist_vld_q <= fin_vld;
            err_q      <= fin_vld && fin_err;
            if (fin_vld) begin
                hist_sets_q <= fin_sets;
                for (int b = 0; b < HIST_BINS; b++) begin
                    hist_q[b*BIN_WIDTH +: BIN_WIDTH] <= fin[b];
                end
            end
        end
    end

    assign bus.hist_out      = hist_q;
    assign bus.hist_valid    = hist_vld_q;
    assign bus.hist_sets     = hist_sets_q;
    assign bus.set_count_err = err_q;

    // Track-word fields outside z0/pt/chi2/hit_mask carry no meaning here
    logic unused_bits;
    assign unused_bits = ^bus.in_tracks;
endmodule

// File: doc/z0_histogram_accumulator.md
# z0_histogram_accumulator

Streaming stage downstream of the track-word unpacking step. Each cycle it takes one set of 18 unpacked track words and bins every valid track by z0 into a 72-bin histogram, weighted by clipped pT. It accumulates all sets of one event and emits the completed histogram once per event. The output feeds the vertex-finding (histogram peak search) stage.

## Interface
- `TRACKS_IN_SET`, 18, tracks per input set
- `HIST_BINS`, 72, number of histogram bins
- `BIN_WIDTH`, 9, bits per bin (saturating)
- `SETS_IN_EVENT`, 95, sets per event
- `PT_MAX`, 127, pT clip value (7-bit)
- `CHI2_MAX`, 10, max accepted 4-bit chi2 (used only with `Z0HIST_QUALITY_CUT_EN`)

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: the input set is valid this cycle
- `in_last` in 1: last set of the event; qualified by `in_valid`
- `in_tracks` in TRACKS_IN_SET×96: `t_track_word_struct` array
- `in_track_valid` in TRACKS_IN_SET: per-track valid; qualified by `in_valid`
- `hist_valid` out 1: one-cycle pulse; `hist_out` holds a complete event
- `hist_out` out HIST_BINS×BIN_WIDTH: bin i is at bits [i*9+8 : i*9]
- `hist_sets` out 7: number of sets accumulated into `hist_out`
- `set_count_err` out 1: one-cycle pulse on an event-length mismatch

## Operation
- No backpressure. A set is accepted on every cycle where `in_valid`=1.
- **Stage 1, per track:**
  - bin = (z0 × 72)[18:12]. z0 is treated as unsigned 12-bit, the product is 19-bit, so bin is in 0..71.
  - w = min(pt[13:0], PT_MAX). pt[14] is the charge bit and is ignored.
  - A track contributes only if `in_valid` and `in_track_valid[t]` are both 1.
- **Stage 2, per bin:** sum the w of all contributing tracks whose bin matches. The sum is 12-bit, with a maximum of 18×127 = 2286.
- **Stage 3, per bin:**
  - acc = min(acc + sum, 511), saturating.
  - If the set is the end of an event: `hist_out` ← min(acc + sum, 511) and acc ← 0 in the same cycle.
  - The next event's first set may arrive on the very next cycle and accumulates from zero.
- **Event end:** the first accepted set that has `in_last`=1, or that is the SETS_IN_EVENT-th set of the event.
- **Set counter:**
  - Increments on each accepted set and resets to 0 after the event end.
  - `hist_sets` = count including the final set.
  - `set_count_err` pulses with `hist_valid` if `in_last`=1 arrived before set 95, or if set 95 arrived with `in_last`=0.
- Gaps with `in_valid`=0 inside an event are allowed. They do not change acc or the counter.

## Timing
- Latency is 3 cycles. A last set sampled at edge N gives `hist_valid`=1 during the cycle after edge N+3.
- `hist_out` holds its value until the next event end.
- Events may run back to back at full throughput.
- Reset (`rst_n`=0, asynchronous):
  - Stage registers, acc and counter are cleared.
  - `hist_valid`=0, `hist_out`=0, `hist_sets`=0, `set_count_err`=0.
  - A reset mid-event discards the partial event with no output.
  - The first set after reset release starts a new event.

## Configuration
- `Z0HIST_QUALITY_CUT_EN` defined: a track also requires chi2 ≤ CHI2_MAX and hit_mask ≠ 0 to contribute.
- Not defined: chi2 and hit_mask are ignored, and only `in_track_valid` gates a track.

## Test plan
- **Single track:** one set with track 0 valid, z0=0, pt=10, `in_last`=1 → 3 cycles later `hist_valid`=1, bin0=10, other bins 0, `hist_sets`=1, `set_count_err`=1.
- **Bin mapping:**
  - z0=2048 → bin 36
  - z0=4095 → bin 71
  - z0=57 → bin 1
  - pt=0x4005 (charge bit set) → weight 5
- **Clip and saturation:**
  - 18 tracks at z0=100 with pt=500 → bin1=511.
  - 95 sets, each with one track of pt=5 in bin 3, `in_last` on set 95 → bin3=475, `hist_sets`=95, no error.
- **Event length, back-to-back events:**
  - 95 sets with `in_last`=0 → output after set 95 with `set_count_err`=1.
  - The next event starts on the following cycle with acc=0, with no gap.
- **Reset mid-event:** drop `rst_n` after 40 sets → all outputs 0. Then a 1-set event with pt=7 in bin 10 → bin10=7 only.
- **Quality cut:** a track with chi2=12, pt=20:
  - With `Z0HIST_QUALITY_CUT_EN` → bin=0.
  - Without it → bin=20.
